ad_frame_ctrl: RTL and testbench
================================

AD_FRAME_CTRL -- requirements
Module: ad_frame_ctrl

Interface
REQ-001 Parameter FRAME_BYTES, default 1024: AD payload bytes per UDP frame, range 16..4096.
REQ-002 Parameter GAP_CYCLES, default 64: idle clk cycles after tx_done before the next tx_start_en.
REQ-003 clk  in  1  single clock, the GMII transmit clock; all logic is on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 ad_data  in  8  AD sample byte, already synchronous to clk.
REQ-006 ad_data_en  in  1  ad_data valid this cycle.
REQ-007 tx_start_en  out  1  one-cycle pulse requesting a UDP frame.
REQ-008 tx_byte_num  out  16  payload byte count of the requested frame.
REQ-009 tx_data  out  8  payload byte, valid the cycle after each tx_req.
REQ-010 tx_req  in  1  payload byte request from the UDP transmitter.
REQ-011 tx_done  in  1  one-cycle pulse at the end of a frame.
REQ-012 ovf_cnt  out  16  saturating count of dropped AD bytes.
REQ-013 frame_cnt  out  16  wrapping count of completed frames.

Function
REQ-014 Storage shall be two banks (ping-pong) of FRAME_BYTES bytes each, with one full flag per bank.
REQ-015 The writer shall store each ad_data_en byte at wr_ptr of the write bank and increment wr_ptr.
REQ-016 On the write with wr_ptr = FRAME_BYTES-1, the writer shall set that bank full, clear wr_ptr to 0, and toggle the write bank.
REQ-017 If the write bank is full, each ad_data_en byte shall be dropped and ovf_cnt incremented, saturating at 16'hFFFF.
REQ-018 Writing shall resume at index 0 of a bank only once that bank is free; partial frames shall never be sent.
REQ-019 The sender FSM states shall be IDLE, START, SEND and GAP.
REQ-020 IDLE: if the read bank is full, go to START; banks shall be read strictly alternately, starting with bank 0.
REQ-021 START: assert tx_start_en for exactly one cycle, clear rd_ptr, go to SEND.
REQ-022 SEND: each tx_req shall present the byte at rd_ptr on tx_data one cycle later (registered RAM read) and increment rd_ptr.
REQ-023 SEND: tx_req with rd_ptr >= tx_byte_num shall be ignored; tx_data holds its last value.
REQ-024 SEND: tx_done shall clear the read bank's full flag, toggle the read bank, increment frame_cnt, and go to GAP.
REQ-025 GAP: count GAP_CYCLES cycles, then go to IDLE.
REQ-026 tx_done outside SEND shall be ignored; tx_req outside SEND shall be ignored.
REQ-027 A bank release (REQ-024) and a dropped write in the same cycle: the byte is dropped and counted, and the writer uses the freed bank from the next cycle.
REQ-028 tx_byte_num shall be constant while a frame is in progress, per REQ-034.

Reset
REQ-029 While rst=1: tx_start_en=0, tx_data=0, tx_byte_num=FRAME_BYTES (+2 with the macro), ovf_cnt=0, frame_cnt=0.
REQ-030 While rst=1: both full flags=0, wr_ptr=0, rd_ptr=0, both bank selects=0, FSM=IDLE, sequence number=0.
REQ-031 Reset asserted mid-frame shall abandon the frame; RAM contents need not be cleared.

Configuration
REQ-032 Macro AD_FRAME_SEQ_EN, when defined, shall prepend a 16-bit frame sequence number to every payload.
REQ-033 With AD_FRAME_SEQ_EN: the first two tx_req of a frame return seq[15:8] then seq[7:0], followed by the RAM bytes.
REQ-034 With AD_FRAME_SEQ_EN: tx_byte_num = FRAME_BYTES+2, and seq increments on each tx_done, wrapping.
REQ-035 Without AD_FRAME_SEQ_EN: tx_byte_num = FRAME_BYTES, and the payload is the RAM bytes only.

Structure
REQ-036 A shared package ad_frame_pkg shall hold the FSM state encoding, the FRAME_BYTES default, and the header length constant (2).
REQ-037 One sub-module, ad_frame_dpram, shall be a simple dual-port RAM: 2*FRAME_BYTES x 8, one write port, one registered read port, single clock.

Verification
REQ-038 FRAME_BYTES=16, 16 bytes 0x00..0x0F with en=1 -> one tx_start_en pulse; 16 tx_req return 0x00..0x0F; tx_done -> frame_cnt=1.
REQ-039 Send 48 bytes with tx_req never asserted -> banks 0 and 1 full, last 16 bytes dropped, ovf_cnt=16, no second tx_start_en until the first tx_done plus GAP_CYCLES.
REQ-040 Assert tx_done on the same cycle as a dropped write -> ovf_cnt increments by 1; the next byte lands at index 0 of the freed bank.
REQ-041 AD_FRAME_SEQ_EN defined, FRAME_BYTES=16, three frames -> tx_byte_num=18; header bytes 00 00, 00 01, 00 02.
REQ-042 Assert rst for 1 cycle during SEND at rd_ptr=5 -> all outputs take their reset values; the next full bank starts at bank 0 with rd_ptr=0.

Source files
------------

// File: rtl/ad_frame_pkg.sv
// Shared definitions for the AD-to-UDP framing controller: sender FSM
// encoding, default frame size and the sequence-header length.
package ad_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SEND  = 2'd2,
        ST_GAP   = 2'd3
    } fsm_state_t;

    localparam int FRAME_BYTES_DEF = 1024;
    localparam int HDR_LEN         = 2;

endpackage

// File: rtl/ad_frame_dpram.sv
// Simple dual-port frame RAM: two banks of FRAME_BYTES bytes laid out
// back to back, one write port and one registered read port on one clock.
// The read register is cleared by reset so the payload output starts at 0.
module ad_frame_dpram
    import ad_frame_pkg::*;
#(
    parameter int FRAME_BYTES = FRAME_BYTES_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_we,
    input  logic [$clog2(2*FRAME_BYTES)-1:0]    i_waddr,
    input  logic [7:0]                          i_wdata,
    input  logic                                i_re,
    input  logic [$clog2(2*FRAME_BYTES)-1:0]    i_raddr,
    output logic [7:0]                          o_rdata
);

    localparam int DEPTH = 2 * FRAME_BYTES;

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata_p1;

    // Write port: store the accepted AD byte.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: one-cycle registered read, holds when not enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata_p1 <= 8'h00;
        end else if (i_re) begin
            r_rdata_p1 <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata_p1;

endmodule

// File: rtl/ad_frame_ctrl.sv
// AD sample framer: buffers AD bytes into a ping-pong pair of banks and
// hands each full bank to a UDP transmitter as one frame.
// Optional feature macro: AD_FRAME_SEQ_EN prepends a 16-bit frame
// sequence number (MSB first) to every payload.
module ad_frame_ctrl
    import ad_frame_pkg::*;
#(
    parameter int FRAME_BYTES = FRAME_BYTES_DEF,
    parameter int GAP_CYCLES  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ad_data,
    input  logic        ad_data_en,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    output logic [7:0]  tx_data,
    input  logic        tx_req,
    input  logic        tx_done,
    output logic [15:0] ovf_cnt,
    output logic [15:0] frame_cnt
);

    localparam int AW = $clog2(2 * FRAME_BYTES);
    localparam int PW = $clog2(FRAME_BYTES);
`ifdef AD_FRAME_SEQ_EN
    localparam int HDR = HDR_LEN;
`else
    localparam int HDR = 0;
`endif
    localparam logic [15:0] BYTE_NUM = 16'(FRAME_BYTES + HDR);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    fsm_state_t      r_state;
    fsm_state_t      w_next_state;
    logic            w_start;
    logic            w_release;

    logic [1:0]      r_full;
    logic [1:0]      w_full_set;
    logic [1:0]      w_full_clr;
    logic            r_wr_bank;
    logic [PW-1:0]   r_wr_ptr;
    logic            r_rd_bank;
    logic [15:0]     r_rd_ptr;
    logic [15:0]     r_gap_cnt;
    logic [15:0]     r_ovf_cnt;
    logic [15:0]     r_frame_cnt;

    logic            w_we;
    logic            w_wr_drop;
    logic            w_wr_last;
    logic [AW-1:0]   w_waddr;
    logic            w_rd_fire;
    logic            w_ram_re;
    logic [15:0]     w_ram_idx;
    logic [AW-1:0]   w_raddr;
    logic [7:0]      w_rdata_p1;

    // ---------------- write side ----------------
    assign w_wr_drop = ad_data_en & r_full[r_wr_bank];
    assign w_we      = ad_data_en & ~r_full[r_wr_bank];
    assign w_wr_last = (r_wr_ptr == PW'(FRAME_BYTES - 1));
    assign w_waddr   = (r_wr_bank ? AW'(FRAME_BYTES) : AW'(0)) + AW'(r_wr_ptr);

    // Writer pointer and bank select; a completed bank flips to the other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_wr_bank <= 1'b0;
        end else if (w_we) begin
            if (w_wr_last) begin
                r_wr_ptr  <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
            end
        end
    end

    // Set and clear never target the same bank: the writer only fills a
    // free bank while the sender only releases a full one.
    assign w_full_set[0] = w_we & w_wr_last & ~r_wr_bank;
    assign w_full_set[1] = w_we & w_wr_last &  r_wr_bank;
    assign w_full_clr[0] = w_release & ~r_rd_bank;
    assign w_full_clr[1] = w_release &  r_rd_bank;

    // Per-bank full flags; a release is seen by the writer one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full | w_full_set) & ~w_full_clr;
        end
    end

    // Dropped-byte counter, sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_cnt <= 16'h0000;
        end else if (w_wr_drop) begin
            r_ovf_cnt <= sat_inc16(r_ovf_cnt);
        end
    end

    // ---------------- sender FSM ----------------
    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and strobes.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                w_start      = 1'b1;
                w_next_state = ST_SEND;
            end
            ST_SEND: begin
                if (tx_done) begin
                    w_release    = 1'b1;
                    w_next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Read bank, frame counter and inter-frame gap counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_bank   <= 1'b0;
            r_frame_cnt <= 16'h0000;
            r_gap_cnt   <= 16'h0000;
        end else begin
            if (w_release) begin
                r_rd_bank   <= ~r_rd_bank;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (r_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt + 16'd1;
            end else begin
                r_gap_cnt <= 16'h0000;
            end
        end
    end

    // Requests beyond the frame length are ignored so tx_data holds.
    assign w_rd_fire = (r_state == ST_SEND) && tx_req && (r_rd_ptr < BYTE_NUM);

    // Read pointer: cleared at frame start, advances on each accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= 16'h0000;
        end else if (r_state == ST_START) begin
            r_rd_ptr <= 16'h0000;
        end else if (w_rd_fire) begin
            r_rd_ptr <= r_rd_ptr + 16'd1;
        end
    end

`ifdef AD_FRAME_SEQ_EN
    logic [15:0] r_seq;
    logic        r_hdr_sel_p1;
    logic [7:0]  r_hdr_byte_p1;

    assign w_ram_re  = w_rd_fire && (r_rd_ptr >= 16'(HDR));
    assign w_ram_idx = r_rd_ptr - 16'(HDR);

    // Sequence number and header byte register, aligned with the RAM read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seq         <= 16'h0000;
            r_hdr_sel_p1  <= 1'b0;
            r_hdr_byte_p1 <= 8'h00;
        end else begin
            if (w_release) begin
                r_seq <= r_seq + 16'd1;
            end
            if (w_rd_fire) begin
                r_hdr_sel_p1 <= (r_rd_ptr < 16'(HDR));
                if (r_rd_ptr == 16'd0) begin
                    r_hdr_byte_p1 <= r_seq[15:8];
                end else begin
                    r_hdr_byte_p1 <= r_seq[7:0];
                end
            end
        end
    end

    assign tx_data = r_hdr_sel_p1 ? r_hdr_byte_p1 : w_rdata_p1;
`else
    assign w_ram_re  = w_rd_fire;
    assign w_ram_idx = r_rd_ptr;
    assign tx_data   = w_rdata_p1;
`endif

    assign w_raddr = (r_rd_bank ? AW'(FRAME_BYTES) : AW'(0)) + AW'(w_ram_idx);

    ad_frame_dpram #(
        .FRAME_BYTES (FRAME_BYTES)
    ) u_dpram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (ad_data),
        .i_re    (w_ram_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata_p1)
    );

    assign tx_start_en = w_start;
    assign tx_byte_num = BYTE_NUM;
    assign ovf_cnt     = r_ovf_cnt;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_ad_frame_ctrl.sv
// Self-checking bench for ad_frame_ctrl (FRAME_BYTES=16, GAP_CYCLES=8).
// Accepted AD bytes are pushed to a scoreboard queue as they are driven and
// popped when the transmitter side reads them back.
module tb_ad_frame_ctrl;

    localparam int FB  = 16;
    localparam int GAP = 8;
`ifdef AD_FRAME_SEQ_EN
    localparam int HDR = 2;
`else
    localparam int HDR = 0;
`endif
    localparam logic [15:0] EXP_BN = 16'(FB + HDR);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ad_data = 8'h00;
    logic        ad_data_en = 1'b0;
    logic        tx_req = 1'b0;
    logic        tx_done = 1'b0;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic [7:0]  tx_data;
    logic [15:0] ovf_cnt;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    ad_frame_ctrl #(
        .FRAME_BYTES (FB),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ad_data     (ad_data),
        .ad_data_en  (ad_data_en),
        .tx_start_en (tx_start_en),
        .tx_byte_num (tx_byte_num),
        .tx_data     (tx_data),
        .tx_req      (tx_req),
        .tx_done     (tx_done),
        .ovf_cnt     (ovf_cnt),
        .frame_cnt   (frame_cnt)
    );

    int checks = 0;
    int fails  = 0;
    int n_start = 0;
    int n_served = 0;

    // Count cycles with tx_start_en high (a two-cycle pulse counts twice).
    always @(posedge clk) begin
        if (tx_start_en === 1'b1) n_start <= n_start + 1;
    end

    // Behavioural model of the buffer state
    bit [1:0]    m_full;
    int          m_wr_bank, m_wr_ptr, m_rd_bank;
    logic [15:0] m_ovf, m_frames, m_seq;
    logic [7:0]  exp_q[$];

    task automatic model_reset();
        m_full = 2'b00; m_wr_bank = 0; m_wr_ptr = 0; m_rd_bank = 0;
        m_ovf = 16'd0; m_frames = 16'd0; m_seq = 16'd0;
        exp_q.delete();
    endtask

    // Drive one clock of inputs (set after a falling edge) and update the model.
    task automatic cyc(input bit en, input logic [7:0] d, input bit req, input bit done);
        ad_data_en = en; ad_data = d; tx_req = req; tx_done = done;
        if (en) begin
            if (!m_full[m_wr_bank]) begin
                exp_q.push_back(d);
                if (m_wr_ptr == FB - 1) begin
                    m_full[m_wr_bank] = 1'b1;
                    m_wr_ptr = 0;
                    m_wr_bank = 1 - m_wr_bank;
                end else begin
                    m_wr_ptr++;
                end
            end else if (m_ovf != 16'hFFFF) begin
                m_ovf = m_ovf + 16'd1;
            end
        end
        if (done) begin
            m_full[m_rd_bank] = 1'b0;
            m_rd_bank = 1 - m_rd_bank;
            m_frames = m_frames + 16'd1;
            m_seq = m_seq + 16'd1;
        end
        @(negedge clk);
        ad_data_en = 1'b0; tx_req = 1'b0; tx_done = 1'b0;
    endtask

    // Wait for a frame start, read n_read bytes, optionally finish the frame.
    task automatic serve(input int n_read, input bit do_done, input bit wr_on_done,
                         input logic [7:0] wd);
        int t;
        logic [7:0] exp_b, last_b;
        t = 0;
        while (n_start <= n_served && t < 300) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
            t++;
        end
        checks++;
        if (t >= 300) begin
            fails++;
            $display("FAIL start_wait: tx_start_en count %0d after %0d cycles, required > %0d",
                     n_start, t, n_served);
            return;
        end
        n_served++;
        checks++;
        if (tx_byte_num !== EXP_BN) begin
            fails++;
            $display("FAIL byte_num: got %0d, required %0d", tx_byte_num, EXP_BN);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        last_b = 8'h00;
        for (int i = 0; i < n_read; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            if (i < HDR) begin
                exp_b = (i == 0) ? m_seq[15:8] : m_seq[7:0];
            end else if (exp_q.size() != 0) begin
                exp_b = exp_q.pop_front();
            end else begin
                exp_b = 8'hxx;
            end
            checks++;
            if (tx_data !== exp_b) begin
                fails++;
                $display("FAIL payload[%0d]: got %02h, required %02h", i, tx_data, exp_b);
            end
            last_b = exp_b;
        end
        if (n_read == FB + HDR) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if (tx_data !== last_b) begin
                fails++;
                $display("FAIL hold_after_end: got %02h, required %02h", tx_data, last_b);
            end
        end
        if (do_done) begin
            cyc(wr_on_done, wd, 1'b0, 1'b1);
            checks++;
            if (frame_cnt !== m_frames) begin
                fails++;
                $display("FAIL frame_cnt: got %0d, required %0d", frame_cnt, m_frames);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (tx_start_en !== 1'b0 || tx_data !== 8'h00 || tx_byte_num !== EXP_BN ||
            ovf_cnt !== 16'd0 || frame_cnt !== 16'd0) begin
            fails++;
            $display("FAIL %s: start=%b data=%02h bn=%0d ovf=%0d fc=%0d, required 0 00 %0d 0 0",
                     tag, tx_start_en, tx_data, tx_byte_num, ovf_cnt, frame_cnt, EXP_BN);
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        rst = 1'b0;
        repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (n_start !== 0) begin
            fails++;
            $display("FAIL idle_no_start: got %0d pulses, required 0", n_start);
        end
    endtask

    task automatic test_single_frame();
        int s0;
        s0 = n_start;
        for (int i = 0; i < FB; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        serve(FB + HDR, 1'b1, 1'b0, 8'h00);
        checks++;
        if (n_start !== s0 + 1) begin
            fails++;
            $display("FAIL single_pulse: got %0d start cycles, required %0d", n_start - s0, 1);
        end
        checks++;
        if (frame_cnt !== 16'd1) begin
            fails++;
            $display("FAIL first_frame_cnt: got %0d, required 1", frame_cnt);
        end
    endtask

    task automatic test_overflow();
        int s0;
        s0 = n_start;
        for (int i = 0; i < 3 * FB; i++) cyc(1'b1, 8'(32 + i), 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (ovf_cnt !== 16'd16) begin
            fails++;
            $display("FAIL ovf_48: got %0d, required 16", ovf_cnt);
        end
        checks++;
        if (n_start !== s0 + 1) begin
            fails++;
            $display("FAIL one_start_while_full: got %0d, required %0d", n_start - s0, 1);
        end
        serve(FB + HDR, 1'b1, 1'b0, 8'h00);
        repeat (GAP + 1) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (n_start !== s0 + 1) begin
            fails++;
            $display("FAIL gap_hold: got %0d starts, required %0d", n_start - s0, 1);
        end
        serve(FB + HDR, 1'b1, 1'b0, 8'h00);
        checks++;
        if (ovf_cnt !== m_ovf) begin
            fails++;
            $display("FAIL ovf_after_drain: got %0d, required %0d", ovf_cnt, m_ovf);
        end
    endtask

    task automatic test_release_drop();
        logic [15:0] ovf0;
        for (int i = 0; i < 2 * FB; i++) cyc(1'b1, 8'(64 + i), 1'b0, 1'b0);
        ovf0 = ovf_cnt;
        serve(FB + HDR, 1'b1, 1'b1, 8'hEE);
        checks++;
        if (ovf_cnt !== ovf0 + 16'd1) begin
            fails++;
            $display("FAIL drop_on_release: got %0d, required %0d", ovf_cnt, ovf0 + 16'd1);
        end
        for (int i = 0; i < FB; i++) cyc(1'b1, 8'(128 + i), 1'b0, 1'b0);
        serve(FB + HDR, 1'b1, 1'b0, 8'h00);
        serve(FB + HDR, 1'b1, 1'b0, 8'h00);
        checks++;
        if (ovf_cnt !== m_ovf) begin
            fails++;
            $display("FAIL ovf_final: got %0d, required %0d", ovf_cnt, m_ovf);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 2 * FB; i++) cyc(1'b1, 8'(192 + i), 1'b0, 1'b0);
        serve(5, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset_values");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (n_start !== n_served) begin
            fails++;
            $display("FAIL no_start_after_reset: got %0d, required %0d", n_start, n_served);
        end
        for (int i = 0; i < FB; i++) cyc(1'b1, 8'(160 + i), 1'b0, 1'b0);
        serve(FB + HDR, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_release_drop();
        test_reset_mid_frame();
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
